apb_i2c_regif_p: RTL and testbench

Parametrised APB slave front-end for the I2C core. It replaces the fixed zero-wait register bridge. It adds back-pressure on a full TX FIFO with a bounded wait and error, and a one-wait-state registered RX read path. It also provides address-decode error reporting and a maskable, sticky interrupt controller. It sits between the APB interconnect and the I2C core's TX/RX FIFOs and configuration inputs.

---
 rtl/apb_i2c_regif_p.sv | 211 +++++++++++++++++++++
 tb/tb_apb_i2c_regif_p.sv | 325 ++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/apb_i2c_regif_p.sv
// APB slave register front-end for the I2C core: TX/RX FIFO access with
// bounded TX back-pressure, one-wait-state RX reads, decode errors and a sticky IRQ.
module apb_i2c_regif_p #(
  parameter int unsigned DATA_W   = 32,
  parameter int unsigned ADDR_W   = 32,
  parameter int unsigned CFG_W    = 14,
  parameter int unsigned TMO_W    = 14,
  parameter int unsigned WAIT_MAX = 16
) (
  input  logic              PCLK,
  input  logic              PRESET,
  input  logic              PSELx,
  input  logic              PENABLE,
  input  logic              PWRITE,
  input  logic [ADDR_W-1:0] PADDR,
  input  logic [DATA_W-1:0] PWDATA,
  output logic [DATA_W-1:0] PRDATA,
  output logic              PREADY,
  output logic              PSLVERR,
  input  logic [DATA_W-1:0] READ_DATA_ON_RX,
  input  logic              TX_FULL,
  input  logic              TX_EMPTY,
  input  logic              RX_EMPTY,
  input  logic              ERROR,
  output logic [DATA_W-1:0] WRITE_DATA_ON_TX,
  output logic              WR_ENA,
  output logic              RD_ENA,
  output logic [CFG_W-1:0]  I2C_CONFIG,
  output logic [TMO_W-1:0]  I2C_TIMEOUT,
  output logic              IRQ
);

  localparam int unsigned CNT_W = (WAIT_MAX < 2) ? 1 : $clog2(WAIT_MAX);

  localparam logic [ADDR_W-1:0] A_TX   = ADDR_W'(8'h00);
  localparam logic [ADDR_W-1:0] A_RX   = ADDR_W'(8'h04);
  localparam logic [ADDR_W-1:0] A_CFG  = ADDR_W'(8'h08);
  localparam logic [ADDR_W-1:0] A_TMO  = ADDR_W'(8'h0C);
  localparam logic [ADDR_W-1:0] A_IST  = ADDR_W'(8'h10);
  localparam logic [ADDR_W-1:0] A_IEN  = ADDR_W'(8'h14);
  localparam logic [ADDR_W-1:0] A_STAT = ADDR_W'(8'h18);

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_WAIT_TX = 2'd1,
    ST_RD_LAT  = 2'd2
  } state_e;

  state_e             state_q, state_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;
  logic [CFG_W-1:0]   cfg_q, cfg_d;
  logic [TMO_W-1:0]   tmo_q, tmo_d;
  logic [3:0]         int_status_q, int_status_d;
  logic [3:0]         int_enable_q, int_enable_d;
  logic               irq_q, irq_d;
  logic               tx_empty_q, tx_empty_d;
  logic               rx_empty_q, rx_empty_d;
  logic               err_q, err_d;

  logic               access;
  logic               hit_tx, hit_rx, hit_cfg, hit_tmo, hit_ist, hit_ien, hit_stat;
  logic               wr_reg, rd_reg;
  logic [DATA_W-1:0]  reg_rdata;

  logic               pready_c, pslverr_c, wr_ena_c, rd_ena_c, reg_we, timeout_ev;
  logic [DATA_W-1:0]  prdata_c;
  logic [3:0]         set_ev, clr_ev;

  assign access   = PSELx & PENABLE;
  assign hit_tx   = (PADDR == A_TX);
  assign hit_rx   = (PADDR == A_RX);
  assign hit_cfg  = (PADDR == A_CFG);
  assign hit_tmo  = (PADDR == A_TMO);
  assign hit_ist  = (PADDR == A_IST);
  assign hit_ien  = (PADDR == A_IEN);
  assign hit_stat = (PADDR == A_STAT);
  assign wr_reg   = PWRITE  & (hit_cfg | hit_tmo | hit_ist | hit_ien);
  assign rd_reg   = !PWRITE & (hit_cfg | hit_tmo | hit_ist | hit_ien | hit_stat);

  always_comb begin
    reg_rdata = '0;
    if (hit_cfg)       reg_rdata[CFG_W-1:0] = cfg_q;
    else if (hit_tmo)  reg_rdata[TMO_W-1:0] = tmo_q;
    else if (hit_ist)  reg_rdata[3:0]       = int_status_q;
    else if (hit_ien)  reg_rdata[3:0]       = int_enable_q;
    else if (hit_stat) reg_rdata[3:0]       = {ERROR, RX_EMPTY, TX_EMPTY, TX_FULL};
  end

  always_comb begin
    state_d    = state_q;
    cnt_d      = cnt_q;
    pready_c   = 1'b0;
    pslverr_c  = 1'b0;
    prdata_c   = '0;
    wr_ena_c   = 1'b0;
    rd_ena_c   = 1'b0;
    reg_we     = 1'b0;
    timeout_ev = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (access) begin
          if (wr_reg) begin
            pready_c = 1'b1;
            reg_we   = 1'b1;
          end else if (rd_reg) begin
            pready_c = 1'b1;
            prdata_c = reg_rdata;
          end else if (PWRITE && hit_tx) begin
            if (!TX_FULL) begin
              wr_ena_c = 1'b1;
              pready_c = 1'b1;
            end else begin
              // This access cycle already counts as the first wait cycle.
              state_d = ST_WAIT_TX;
              cnt_d   = CNT_W'(1);
            end
          end else if (!PWRITE && hit_rx) begin
            if (!RX_EMPTY) begin
              rd_ena_c = 1'b1;
              state_d  = ST_RD_LAT;
            end else begin
              pready_c  = 1'b1;
              pslverr_c = 1'b1;
            end
          end else begin
            pready_c  = 1'b1;
            pslverr_c = 1'b1;
          end
        end
      end
      ST_WAIT_TX: begin
        if (!PSELx) begin
          state_d = ST_IDLE;
        end else if (!TX_FULL) begin
          wr_ena_c = 1'b1;
          pready_c = 1'b1;
          state_d  = ST_IDLE;
        end else if (cnt_q >= CNT_W'(WAIT_MAX - 1)) begin
          pready_c   = 1'b1;
          pslverr_c  = 1'b1;
          timeout_ev = 1'b1;
          state_d    = ST_IDLE;
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end
      ST_RD_LAT: begin
        pready_c = 1'b1;
        prdata_c = READ_DATA_ON_RX;
        state_d  = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_comb begin
    cfg_d        = cfg_q;
    tmo_d        = tmo_q;
    int_enable_d = int_enable_q;
    clr_ev       = '0;
    if (reg_we && hit_cfg) cfg_d        = PWDATA[CFG_W-1:0];
    if (reg_we && hit_tmo) tmo_d        = PWDATA[TMO_W-1:0];
    if (reg_we && hit_ien) int_enable_d = PWDATA[3:0];
    if (reg_we && hit_ist) clr_ev       = PWDATA[3:0];
    set_ev       = {timeout_ev, ERROR & ~err_q, rx_empty_q & ~RX_EMPTY, TX_EMPTY & ~tx_empty_q};
    // Set is applied after clear so a simultaneous event wins over W1C.
    int_status_d = (int_status_q & ~clr_ev) | set_ev;
    irq_d        = |(int_status_q & int_enable_q);
    tx_empty_d   = TX_EMPTY;
    rx_empty_d   = RX_EMPTY;
    err_d        = ERROR;
  end

  always_ff @(posedge PCLK or posedge PRESET) begin
    if (PRESET) begin
      state_q      <= ST_IDLE;
      cnt_q        <= '0;
      cfg_q        <= '0;
      tmo_q        <= '0;
      int_status_q <= '0;
      int_enable_q <= '0;
      irq_q        <= 1'b0;
      tx_empty_q   <= 1'b1;
      rx_empty_q   <= 1'b1;
      err_q        <= 1'b0;
    end else begin
      state_q      <= state_d;
      cnt_q        <= cnt_d;
      cfg_q        <= cfg_d;
      tmo_q        <= tmo_d;
      int_status_q <= int_status_d;
      int_enable_q <= int_enable_d;
      irq_q        <= irq_d;
      tx_empty_q   <= tx_empty_d;
      rx_empty_q   <= rx_empty_d;
      err_q        <= err_d;
    end
  end

  // Bus-facing strobes are forced low while reset is held, even mid-transfer.
  assign PREADY           = pready_c  & ~PRESET;
  assign PSLVERR          = pslverr_c & ~PRESET;
  assign WR_ENA           = wr_ena_c  & ~PRESET;
  assign RD_ENA           = rd_ena_c  & ~PRESET;
  assign PRDATA           = PRESET ? '0 : prdata_c;
  assign WRITE_DATA_ON_TX = PRESET ? '0 : PWDATA;
  assign I2C_CONFIG       = cfg_q;
  assign I2C_TIMEOUT      = tmo_q;
  assign IRQ              = irq_q;

endmodule

// File: tb/tb_apb_i2c_regif_p.sv
// Bench for apb_i2c_regif_p: vector table, directed corner sequences and
// randomized transactions against a transaction-level reference model.
module tb_apb_i2c_regif_p;

  localparam int unsigned WMAX = 16;

  logic        PCLK = 1'b0;
  logic        PRESET, PSELx, PENABLE, PWRITE;
  logic [31:0] PADDR, PWDATA, PRDATA, READ_DATA_ON_RX, WRITE_DATA_ON_TX;
  logic        PREADY, PSLVERR, TX_FULL, TX_EMPTY, RX_EMPTY, ERROR;
  logic        WR_ENA, RD_ENA, IRQ;
  logic [13:0] I2C_CONFIG, I2C_TIMEOUT;

  apb_i2c_regif_p #(
    .DATA_W  (32),
    .ADDR_W  (32),
    .CFG_W   (14),
    .TMO_W   (14),
    .WAIT_MAX(WMAX)
  ) dut (
    .PCLK            (PCLK),
    .PRESET          (PRESET),
    .PSELx           (PSELx),
    .PENABLE         (PENABLE),
    .PWRITE          (PWRITE),
    .PADDR           (PADDR),
    .PWDATA          (PWDATA),
    .PRDATA          (PRDATA),
    .PREADY          (PREADY),
    .PSLVERR         (PSLVERR),
    .READ_DATA_ON_RX (READ_DATA_ON_RX),
    .TX_FULL         (TX_FULL),
    .TX_EMPTY        (TX_EMPTY),
    .RX_EMPTY        (RX_EMPTY),
    .ERROR           (ERROR),
    .WRITE_DATA_ON_TX(WRITE_DATA_ON_TX),
    .WR_ENA          (WR_ENA),
    .RD_ENA          (RD_ENA),
    .I2C_CONFIG      (I2C_CONFIG),
    .I2C_TIMEOUT     (I2C_TIMEOUT),
    .IRQ             (IRQ)
  );

  always #5 PCLK = ~PCLK;

  int total = 0;
  int bad   = 0;

  // Reference model state
  logic [13:0] m_cfg, m_tmo;
  logic [3:0]  m_ist, m_ien, pend_clr;
  logic        m_irq, pend_to, p_txe, p_rxe, p_err;

  // Per-cycle samples and per-transaction results
  logic        s_pready, s_pslverr, s_wr, s_rd, s_irq;
  logic [31:0] s_prdata, s_wdata;
  int          r_n, r_wr, r_wok, r_rd, r_rd_cyc;
  logic        r_err;
  logic [31:0] r_rdata;

  typedef struct packed {
    logic        wr;
    logic [31:0] addr;
    logic [31:0] wd;
    logic        exp_err;
    logic [31:0] exp_rd;
  } vec_t;

  vec_t tbl [19];

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", nm, act, exp);
    end
  endtask

  task automatic model_reset();
    m_cfg = '0; m_tmo = '0; m_ist = '0; m_ien = '0; m_irq = 1'b0;
    p_txe = 1'b1; p_rxe = 1'b1; p_err = 1'b0;
    pend_clr = '0; pend_to = 1'b0;
  endtask

  task automatic model_commit(input logic [31:0] addr, input logic [31:0] wd);
    case (addr)
      32'h08: m_cfg = wd[13:0];
      32'h0C: m_tmo = wd[13:0];
      32'h14: m_ien = wd[3:0];
      default: ;
    endcase
  endtask

  // One clock: sample outputs mid-cycle, then advance the model across the edge.
  task automatic step();
    logic       irq_new;
    logic [3:0] set;
    @(negedge PCLK); #1;
    s_pready = PREADY; s_pslverr = PSLVERR; s_prdata = PRDATA;
    s_wr = WR_ENA; s_rd = RD_ENA; s_wdata = WRITE_DATA_ON_TX; s_irq = IRQ;
    chk("irq", s_irq, m_irq);
    if (!(PSELx && PENABLE)) chk("quiet", {s_pready, s_wr, s_rd}, 3'b000);
    irq_new = |(m_ist & m_ien);
    set = {pend_to, ERROR & ~p_err, p_rxe & ~RX_EMPTY, TX_EMPTY & ~p_txe};
    @(posedge PCLK);
    m_ist = (m_ist & ~pend_clr) | set;
    m_irq = irq_new;
    p_txe = TX_EMPTY; p_rxe = RX_EMPTY; p_err = ERROR;
    pend_clr = '0; pend_to = 1'b0;
    #1;
  endtask

  // Setup phase plus bounded access phase; TX_FULL is high for the first 'hold' access cycles.
  task automatic apb(input logic wr, input logic [31:0] addr, input logic [31:0] wd,
                     input int hold, input int exp_n, input logic [3:0] clr, input logic to);
    PWRITE = wr; PADDR = addr; PWDATA = wd; PSELx = 1'b1; PENABLE = 1'b0;
    step();
    r_n = 0; r_wr = 0; r_wok = 0; r_rd = 0; r_rd_cyc = 0; r_err = 1'b0; r_rdata = '0;
    for (int i = 1; i <= 40; i++) begin
      PENABLE = 1'b1;
      TX_FULL = (i <= hold);
      if (i == exp_n) begin pend_clr = clr; pend_to = to; end
      step();
      if (s_wr) begin r_wr++; if (s_wdata == wd) r_wok++; end
      if (s_rd) begin r_rd++; r_rd_cyc = i; end
      if (s_pready) begin
        r_n = i; r_err = s_pslverr; r_rdata = s_prdata;
        break;
      end
    end
    if (r_n == 0) chk("txn_done", 1'b0, 1'b1);
    PSELx = 1'b0; PENABLE = 1'b0;
  endtask

  task automatic do_txn(input logic wr, input logic [31:0] addr, input logic [31:0] wd, input int hold);
    int h, en, ewr, erdn;
    logic eerr, to;
    logic [31:0] erd;
    logic [3:0] clr;
    h = (wr && addr == 32'h0) ? hold : (TX_FULL ? 1000 : 0);
    en = 1; ewr = 0; erdn = 0; eerr = 1'b0; to = 1'b0; erd = '0; clr = '0;
    if (wr) begin
      case (addr)
        32'h00: begin
          if (h == 0) ewr = 1;
          else if (h >= int'(WMAX)) begin en = WMAX; eerr = 1'b1; to = 1'b1; end
          else begin en = h + 1; ewr = 1; end
        end
        32'h08, 32'h0C, 32'h14: ;
        32'h10: clr = wd[3:0];
        default: eerr = 1'b1;
      endcase
    end else begin
      case (addr)
        32'h04: if (!RX_EMPTY) begin en = 2; erdn = 1; erd = READ_DATA_ON_RX; end else eerr = 1'b1;
        32'h08: erd = {18'b0, m_cfg};
        32'h0C: erd = {18'b0, m_tmo};
        32'h10: erd = {28'b0, m_ist};
        32'h14: erd = {28'b0, m_ien};
        32'h18: erd = {28'b0, ERROR, RX_EMPTY, TX_EMPTY, (h >= 1)};
        default: eerr = 1'b1;
      endcase
    end
    apb(wr, addr, wd, h, en, clr, to);
    chk("n_cycles", r_n, en);
    chk("pslverr", r_err, eerr);
    if (!wr) chk("prdata", r_rdata, erd);
    chk("wr_ena_cnt", r_wr, ewr);
    chk("tx_wdata", r_wok, ewr);
    chk("rd_ena_cnt", r_rd, erdn);
    if (erdn != 0) chk("rd_ena_cycle", r_rd_cyc, 1);
    if (wr && !eerr) model_commit(addr, wd);
    chk("cfg_tmo_out", {I2C_CONFIG, I2C_TIMEOUT}, {m_cfg, m_tmo});
  endtask

  logic [31:0] alist [10];

  initial begin
    tbl[0]  = '{1'b1, 32'h08,        32'h0000_3ABC, 1'b0, 32'h0};
    tbl[1]  = '{1'b0, 32'h08,        32'h0,         1'b0, 32'h3ABC};
    tbl[2]  = '{1'b1, 32'h0C,        32'hFFFF_FFFF, 1'b0, 32'h0};
    tbl[3]  = '{1'b0, 32'h0C,        32'h0,         1'b0, 32'h3FFF};
    tbl[4]  = '{1'b1, 32'h1C,        32'h0000_0001, 1'b1, 32'h0};
    tbl[5]  = '{1'b1, 32'h18,        32'h0000_0005, 1'b1, 32'h0};
    tbl[6]  = '{1'b0, 32'h00,        32'h0,         1'b1, 32'h0};
    tbl[7]  = '{1'b1, 32'h0A,        32'h1234_5678, 1'b1, 32'h0};
    tbl[8]  = '{1'b1, 32'h04,        32'h0000_0077, 1'b1, 32'h0};
    tbl[9]  = '{1'b0, 32'h1C,        32'h0,         1'b1, 32'h0};
    tbl[10] = '{1'b0, 32'h08,        32'h0,         1'b0, 32'h3ABC};
    tbl[11] = '{1'b0, 32'h0C,        32'h0,         1'b0, 32'h3FFF};
    tbl[12] = '{1'b0, 32'h18,        32'h0,         1'b0, 32'h6};
    tbl[13] = '{1'b0, 32'h10,        32'h0,         1'b0, 32'h0};
    tbl[14] = '{1'b1, 32'h14,        32'hFFFF_FFF5, 1'b0, 32'h0};
    tbl[15] = '{1'b0, 32'h14,        32'h0,         1'b0, 32'h5};
    tbl[16] = '{1'b1, 32'h14,        32'h0,         1'b0, 32'h0};
    tbl[17] = '{1'b0, 32'h02,        32'h0,         1'b1, 32'h0};
    tbl[18] = '{1'b0, 32'h1000_0008, 32'h0,         1'b1, 32'h0};
    alist = '{32'h00, 32'h04, 32'h08, 32'h0C, 32'h10, 32'h14, 32'h18, 32'h1C, 32'h06, 32'h100C};

    // Reset with a live access on the bus: nothing may complete.
    PRESET = 1'b0; PSELx = 1'b1; PENABLE = 1'b1; PWRITE = 1'b1; PADDR = 32'h08;
    PWDATA = 32'hFFFF_FFFF; READ_DATA_ON_RX = 32'h0;
    TX_FULL = 1'b0; TX_EMPTY = 1'b1; RX_EMPTY = 1'b1; ERROR = 1'b0;
    #2 PRESET = 1'b1;
    #10;
    chk("rst_strobes", {PREADY, PSLVERR, WR_ENA, RD_ENA, IRQ}, 5'b0);
    chk("rst_prdata", PRDATA, 32'h0);
    chk("rst_regs", {I2C_CONFIG, I2C_TIMEOUT}, 28'h0);
    @(posedge PCLK); #1;
    PSELx = 1'b0; PENABLE = 1'b0; PRESET = 1'b0;
    model_reset();
    step();

    // Zero-wait register / decode-error vectors
    for (int i = 0; i < 19; i++) begin
      apb(tbl[i].wr, tbl[i].addr, tbl[i].wd, 0, 1, 4'b0, 1'b0);
      chk($sformatf("vec%0d_n", i), r_n, 1);
      chk($sformatf("vec%0d_err", i), r_err, tbl[i].exp_err);
      if (!tbl[i].wr) chk($sformatf("vec%0d_rdata", i), r_rdata, tbl[i].exp_rd);
      chk($sformatf("vec%0d_fifo", i), r_wr + r_rd, 0);
      if (tbl[i].wr && !tbl[i].exp_err) model_commit(tbl[i].addr, tbl[i].wd);
      step();
    end
    chk("cfg_after_vecs", I2C_CONFIG, 14'h3ABC);

    // TX_FULL held: bounded wait then error
    do_txn(1'b1, 32'h0, 32'hA5A5_A5A5, 1000);
    chk("to_cycles", r_n, WMAX);
    chk("to_err", r_err, 1'b1);
    chk("to_no_write", r_wr, 0);
    TX_FULL = 1'b0; step();
    do_txn(1'b0, 32'h10, 32'h0, 0);
    chk("to_ist", r_rdata, 32'h8);
    do_txn(1'b1, 32'h10, 32'hF, 0);

    // TX_FULL drops after 3 wait cycles
    do_txn(1'b1, 32'h0, 32'h5A5A_1234, 3);
    chk("drop_cycles", r_n, 4);
    chk("drop_wr", r_wr, 1);
    chk("drop_wdata", r_wok, 1);
    chk("drop_err", r_err, 1'b0);

    // RX read with data, then from an empty FIFO
    RX_EMPTY = 1'b0; READ_DATA_ON_RX = 32'hDEAD_BEEF; step();
    do_txn(1'b0, 32'h04, 32'h0, 0);
    chk("rx_rdata", r_rdata, 32'hDEAD_BEEF);
    chk("rx_cycles", r_n, 2);
    RX_EMPTY = 1'b1; step();
    do_txn(1'b0, 32'h04, 32'h0, 0);
    chk("rx_empty_err", {r_err, r_rdata}, {1'b1, 32'h0});

    // Interrupt: ERROR rise, W1C colliding with a new rise, then a clean W1C
    do_txn(1'b1, 32'h10, 32'hF, 0);
    do_txn(1'b1, 32'h14, 32'h4, 0);
    ERROR = 1'b1; step();
    step(); step();
    chk("irq_on", s_irq, 1'b1);
    ERROR = 1'b0; step();
    PWRITE = 1'b1; PADDR = 32'h10; PWDATA = 32'h4; PSELx = 1'b1; PENABLE = 1'b0;
    step();
    PENABLE = 1'b1; ERROR = 1'b1; pend_clr = 4'h4;
    step();
    chk("w1c_collide_ready", {s_pready, s_pslverr}, 2'b10);
    PSELx = 1'b0; PENABLE = 1'b0;
    step();
    do_txn(1'b0, 32'h10, 32'h0, 0);
    chk("set_wins", r_rdata[2], 1'b1);
    do_txn(1'b1, 32'h10, 32'h4, 0);
    step(); step();
    chk("irq_off", s_irq, 1'b0);
    ERROR = 1'b0; step();

    // Randomized traffic against the model
    for (int it = 0; it < 250; it++) begin
      case ($urandom_range(0, 5))
        0: begin
          TX_EMPTY = 1'($urandom); RX_EMPTY = 1'($urandom); ERROR = 1'($urandom);
          TX_FULL = 1'($urandom); READ_DATA_ON_RX = $urandom;
          step();
        end
        1: do_txn(1'b1, 32'h0, $urandom, $urandom_range(0, 20));
        2: do_txn(1'b0, 32'h04, 32'h0, 0);
        3: do_txn(1'($urandom), alist[$urandom_range(0, 9)], $urandom, 0);
        4: do_txn(1'b1, ($urandom_range(0, 1) != 0) ? 32'h10 : 32'h14, $urandom, 0);
        default: do_txn(1'b0, alist[$urandom_range(2, 6)], 32'h0, 0);
      endcase
    end

    // Asynchronous reset in the middle of a TX wait
    TX_EMPTY = 1'b1; RX_EMPTY = 1'b1; ERROR = 1'b0; TX_FULL = 1'b0; step();
    do_txn(1'b1, 32'h08, 32'h1234, 0);
    do_txn(1'b1, 32'h10, 32'hF, 0);
    do_txn(1'b1, 32'h14, 32'h4, 0);
    ERROR = 1'b1; step(); step(); step();
    chk("irq_before_rst", s_irq, 1'b1);
    PWRITE = 1'b1; PADDR = 32'h0; PWDATA = 32'hCAFE_F00D; TX_FULL = 1'b1;
    PSELx = 1'b1; PENABLE = 1'b0;
    step();
    PENABLE = 1'b1;
    step(); step(); step();
    chk("wait_low", {s_pready, s_wr}, 2'b00);
    @(negedge PCLK); #2 PRESET = 1'b1; #1;
    chk("arst_strobes", {PREADY, PSLVERR, WR_ENA, RD_ENA, IRQ}, 5'b0);
    chk("arst_data", {PRDATA, WRITE_DATA_ON_TX}, 64'h0);
    chk("arst_regs", {I2C_CONFIG, I2C_TIMEOUT}, 28'h0);
    @(posedge PCLK); #1;
    PSELx = 1'b0; PENABLE = 1'b0; TX_FULL = 1'b0; PRESET = 1'b0;
    model_reset();
    step(); step();
    do_txn(1'b0, 32'h08, 32'h0, 0);
    chk("post_rst_cfg", r_rdata, 32'h0);
    do_txn(1'b0, 32'h14, 32'h0, 0);
    chk("post_rst_ien", r_rdata, 32'h0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #2_000_000;
    $display("FAIL global_timeout: got running expected finished");
    $fatal(1, "timeout");
  end

endmodule
